// File: rtl/divider_pkg.sv
// Shared definitions for the sequential 16-bit divider.
// Contents: FSM state enum, datapath width and step count,
// the divide-by-zero quotient constant, the most negative 16-bit value,
// and two's-complement helpers used for operand and result sign handling.
package divider_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_STEPS = 16;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = 16'hFFFF;
  localparam logic [DIV_WIDTH-1:0] SIGNED_MIN        = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Invert and add one.
  function automatic logic [DIV_WIDTH-1:0] twos_neg(input logic [DIV_WIDTH-1:0] v);
    return ~v + DIV_WIDTH'(1);
  endfunction

  // Magnitude of a two's-complement value; -32768 maps to 16'h8000,
  // which is the correct unsigned magnitude.
  function automatic logic [DIV_WIDTH-1:0] abs16(input logic [DIV_WIDTH-1:0] v);
    return v[DIV_WIDTH-1] ? twos_neg(v) : v;
  endfunction

endpackage

// File: rtl/AdderSubtractor16BitOverflow.sv
// 16-bit adder-subtractor with carry and signed overflow outputs.
// Ports:
//   a_i, b_i     operands
//   sub_i        1 = a_i - b_i (a + ~b + 1), 0 = a_i + b_i
//   sum_o        result
//   carry_out_o  carry out of bit 15; when subtracting, 1 means no borrow
//   overflow_o   signed overflow of the operation
module AdderSubtractor16BitOverflow
  import divider_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] a_i,
  input  logic [DIV_WIDTH-1:0] b_i,
  input  logic                 sub_i,
  output logic [DIV_WIDTH-1:0] sum_o,
  output logic                 carry_out_o,
  output logic                 overflow_o
);

  logic [DIV_WIDTH-1:0] b_eff;

  assign b_eff = b_i ^ {DIV_WIDTH{sub_i}};
  assign {carry_out_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{DIV_WIDTH{1'b0}}, sub_i};
  // Overflow when both effective operands share a sign the result does not.
  assign overflow_o = (a_i[DIV_WIDTH-1] == b_eff[DIV_WIDTH-1]) &&
                      (sum_o[DIV_WIDTH-1] != a_i[DIV_WIDTH-1]);

endmodule

// File: rtl/divider_16bit_sequential.sv
// Multi-cycle restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   start               request, sampled only in IDLE
//   signed_mode         1 = two's-complement operands (captured with start)
//   dividend, divisor   operands (captured with start)
//   busy                high in every state but IDLE
//   done                one-cycle pulse, results valid from then on
//   quotient, remainder results; remainder sign follows the dividend
//   div_by_zero         divisor was 0 (quotient FFFF, remainder = dividend)
//   signed_overflow     signed -32768 / -1
//   zero_flag           quotient == 0
//   negative_flag       quotient[15] in signed mode, else 0
// Handshake: start is only honoured while busy is low; done marks the first
// cycle the result registers hold the new values, which then persist until
// the next accepted operation completes.
module divider_16bit_sequential
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             signed_overflow,
  output logic             zero_flag,
  output logic             negative_flag
);

  div_state_e           state_q;
  logic [4:0]           cnt_q;
  logic [WIDTH:0]       r_q;       // 17-bit partial remainder
  logic [WIDTH-1:0]     q_q;       // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]     dvs_q;     // divisor magnitude
  logic                 q_sign_q;
  logic                 r_sign_q;
  logic                 ovf_pend_q;
  logic                 signed_q;

  logic                 busy_q, done_q, dbz_q, ovf_q, zero_q, neg_q;
  logic [WIDTH-1:0]     quotient_q, remainder_q;

  logic [WIDTH:0]       r_shift;
  logic [WIDTH-1:0]     trial;
  logic                 trial_carry;
  logic                 adder_ovf_unused;
  logic                 no_borrow;
  logic [WIDTH:0]       r_d;
  logic [WIDTH-1:0]     q_d;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;

  assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  AdderSubtractor16BitOverflow u_trial_sub (
    .a_i         (r_shift[WIDTH-1:0]),
    .b_i         (dvs_q),
    .sub_i       (1'b1),
    .sum_o       (trial),
    .carry_out_o (trial_carry),
    .overflow_o  (adder_ovf_unused)
  );

  // Bit 16 of the shifted remainder means it already exceeds any 16-bit
  // divisor, so the subtraction succeeds even if the 16-bit adder borrows.
  assign no_borrow = r_shift[WIDTH] | trial_carry;

  always_comb begin
    r_d = r_shift;
    q_d = {q_q[WIDTH-2:0], 1'b0};
    if (no_borrow) begin
      r_d = {1'b0, trial};
      q_d = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  assign q_fix = q_sign_q ? twos_neg(q_q) : q_q;
  assign r_fix = r_sign_q ? twos_neg(r_q[WIDTH-1:0]) : r_q[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      q_sign_q    <= 1'b0;
      r_sign_q    <= 1'b0;
      ovf_pend_q  <= 1'b0;
      signed_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (divisor == '0) begin
              quotient_q  <= DIV_ZERO_QUOTIENT;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              ovf_q       <= 1'b0;
              zero_q      <= (DIV_ZERO_QUOTIENT == '0);
              neg_q       <= signed_mode & DIV_ZERO_QUOTIENT[WIDTH-1];
              state_q     <= DONE;
            end else begin
              q_q        <= signed_mode ? abs16(dividend) : dividend;
              dvs_q      <= signed_mode ? abs16(divisor) : divisor;
              r_q        <= '0;
              cnt_q      <= '0;
              q_sign_q   <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_sign_q   <= signed_mode & dividend[WIDTH-1];
              ovf_pend_q <= signed_mode & (dividend == SIGNED_MIN) & (divisor == '1);
              signed_q   <= signed_mode;
              state_q    <= ITER;
            end
          end
        end
        ITER: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_STEPS - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quotient_q  <= q_fix;
          remainder_q <= r_fix;
          dbz_q       <= 1'b0;
          ovf_q       <= ovf_pend_q;
          zero_q      <= (q_fix == '0);
          neg_q       <= signed_q & q_fix[WIDTH-1];
          done_q      <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          // Entered directly from IDLE on divide-by-zero with done low:
          // spend one cycle raising done so that path also pulses done once.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign quotient        = quotient_q;
  assign remainder       = remainder_q;
  assign div_by_zero     = dbz_q;
  assign signed_overflow = ovf_q;
  assign zero_flag       = zero_q;
  assign negative_flag   = neg_q;

endmodule

// File: tb/tb_divider_16bit_sequential.sv
// Directed bench for divider_16bit_sequential: reset values, unsigned and
// signed divisions, divide-by-zero, signed overflow, unsigned divisors at
// and above 16'h8000, start-while-busy and asynchronous reset mid-operation.
module tb_divider_16bit_sequential;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        signed_overflow;
  logic        zero_flag;
  logic        negative_flag;

  int n_vectors     = 0;
  int n_miscompares = 0;

  divider_16bit_sequential #(.WIDTH(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .signed_mode     (signed_mode),
    .dividend        (dividend),
    .divisor         (divisor),
    .busy            (busy),
    .done            (done),
    .quotient        (quotient),
    .remainder       (remainder),
    .div_by_zero     (div_by_zero),
    .signed_overflow (signed_overflow),
    .zero_flag       (zero_flag),
    .negative_flag   (negative_flag)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vectors++;
    assert (got === exp) else begin
      n_miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    n_vectors++;
    assert (got === exp) else begin
      n_miscompares++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance edge by edge until done is seen, bounded to 40 edges.
  // lat counts edges from the start-sampling edge (that edge is 1).
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] eq, input logic [15:0] er,
                               input logic edbz, input logic eovf, input logic ez, input logic en);
    check16({tag, ".quotient"},  quotient,  eq);
    check16({tag, ".remainder"}, remainder, er);
    check1 ({tag, ".dbz"},       div_by_zero,     edbz);
    check1 ({tag, ".ovf"},       signed_overflow, eovf);
    check1 ({tag, ".zero"},      zero_flag,       ez);
    check1 ({tag, ".neg"},       negative_flag,   en);
  endtask

  // One complete operation: drive start for one edge, scramble operands
  // afterwards (they must have been captured), wait for done, check the
  // result and latency, then check that done was a single-cycle pulse.
  task automatic run_op(input string tag, input logic sm, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                        input logic eovf, input logic ez, input logic en, input int exp_lat);
    int lat;
    signed_mode = sm;
    dividend    = a;
    divisor     = b;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    signed_mode = 1'($urandom_range(0, 1));
    dividend    = 16'($urandom_range(0, 65535));
    divisor     = 16'($urandom_range(0, 65535));
    check1({tag, ".busy"}, busy, 1'b1);
    wait_done(1, lat);
    check16({tag, ".latency"}, 16'(lat), 16'(exp_lat));
    check_outputs(tag, eq, er, edbz, eovf, ez, en);
    @(posedge clk);
    #1;
    check1({tag, ".done_pulse"}, done, 1'b0);
    check1({tag, ".idle"},       busy, 1'b0);
  endtask

  initial begin
    int  lat;
    logic seen_done;

    // reset
    rst         = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    dividend    = '0;
    divisor     = '0;
    repeat (3) @(posedge clk);
    #1;
    check1("reset.busy", busy, 1'b0);
    check1("reset.done", done, 1'b0);
    check_outputs("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    //     tag           sm    dividend  divisor   quot      rem       dbz   ovf   zero  neg   lat
    run_op("u100_7",     1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 1'b0, 1'b0, 18);
    run_op("s-100_7",    1'b1, 16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 18);
    run_op("u1234_0",    1'b0, 16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    run_op("u10_5",      1'b0, 16'd10,   16'd5,    16'd2,    16'd0,    1'b0, 1'b0, 1'b0, 1'b0, 18);
    run_op("s_min_-1",   1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 18);
    run_op("uFFFF_FFFF", 1'b0, 16'hFFFF, 16'hFFFF, 16'd1,    16'd0,    1'b0, 1'b0, 1'b0, 1'b0, 18);
    run_op("uFFFE_FFFF", 1'b0, 16'hFFFE, 16'hFFFF, 16'd0,    16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 18);
    run_op("u0_3",       1'b0, 16'd0,    16'd3,    16'd0,    16'd0,    1'b0, 1'b0, 1'b1, 1'b0, 18);
    run_op("s100_-7",    1'b1, 16'd100,  16'hFFF9, 16'hFFF2, 16'd2,    1'b0, 1'b0, 1'b0, 1'b1, 18);
    run_op("s-100_-7",   1'b1, 16'hFF9C, 16'hFFF9, 16'd14,   16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 18);
    run_op("uFFFF_8000", 1'b0, 16'hFFFF, 16'h8000, 16'd1,    16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 18);
    run_op("u8000_FFFF", 1'b0, 16'h8000, 16'hFFFF, 16'd0,    16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 18);
    run_op("s-5_0",      1'b1, 16'hFFFB, 16'd0,    16'hFFFF, 16'hFFFB, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    run_op("s-7_2",      1'b1, 16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 18);

    // start while busy is ignored
    signed_mode = 1'b0;
    dividend    = 16'd100;
    divisor     = 16'd7;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check1("busy_ign.busy", busy, 1'b1);
    wait_done(6, lat);
    check16("busy_ign.latency", 16'(lat), 16'd18);
    check_outputs("busy_ign", 16'd14, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check1("busy_ign.idle", busy, 1'b0);

    // asynchronous reset mid-operation
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check1("midrst.busy", busy, 1'b0);
    check1("midrst.done", done, 1'b0);
    check_outputs("midrst", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    check1("midrst.no_done", seen_done, 1'b0);
    check1("midrst.still_idle", busy, 1'b0);

    // recovery after reset
    run_op("post_rst",   1'b0, 16'd1000, 16'd33,   16'd30,   16'd10,   1'b0, 1'b0, 1'b0, 1'b0, 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
